// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and arbitration helpers for the unified memory-port arbiter.
// Port indices, priority order and the winner-selection function live here.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam int NUM_PORTS = 3;
  localparam int PORT_IF   = 0;
  localparam int PORT_MEM  = 1;
  localparam int PORT_VEC  = 2;

  // Priority order, highest first: mem > if > vec
  localparam logic [1:0] PRIO_FIRST  = 2'(PORT_MEM);
  localparam logic [1:0] PRIO_SECOND = 2'(PORT_IF);
  localparam logic [1:0] PRIO_THIRD  = 2'(PORT_VEC);
  localparam logic [5:0] PRIO_ORDER  = {PRIO_THIRD, PRIO_SECOND, PRIO_FIRST};

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } winner_t;

  // Aged requesters form the candidate set when any exist; otherwise all requesters do.
  function automatic winner_t pick_winner(input logic [NUM_PORTS-1:0] req,
                                          input logic [NUM_PORTS-1:0] aged);
    winner_t               w;
    logic [NUM_PORTS-1:0]  cand;
    logic [1:0]            p;
    cand = ((req & aged) != '0) ? (req & aged) : req;
    w.valid = 1'b0;
    w.idx   = PRIO_FIRST;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      p = PRIO_ORDER[2*i +: 2];
      if (cand[p]) begin
        w.valid = 1'b1;
        w.idx   = p;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_age_counter.sv
// Per-requester wait counter: counts cycles spent requesting without a grant,
// saturating at limit; aged flags that the requester must be served next.
module age_counter (
  input  logic       clk,
  input  logic       rstn,
  input  logic       inc,
  input  logic       clr,
  input  logic [7:0] limit,
  output logic       aged
);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt_reg <= 8'd0;
    end else if (inc && (cnt_reg < limit)) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  assign aged = (cnt_reg == limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between IF, MEM and vector requesters,
// one outstanding transaction at a time, with aging to prevent starvation.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int AGE_MAX = 8
) (
  input  logic                clk,
  input  logic                rstn,

  input  logic                if_req,
  input  logic                if_we,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic [DATA_W-1:0]   if_wdata,
  input  logic [DATA_W/8-1:0] if_wstrb,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,

  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_gnt,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err,

  input  logic                vec_req,
  input  logic                vec_we,
  input  logic [ADDR_W-1:0]   vec_addr,
  input  logic [DATA_W-1:0]   vec_wdata,
  input  logic [DATA_W/8-1:0] vec_wstrb,
  output logic                vec_gnt,
  output logic                vec_rvalid,
  output logic [DATA_W-1:0]   vec_rdata,
  output logic                vec_err,

  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_err
);

  localparam int         SW        = DATA_W / 8;
  localparam logic [7:0] AGE_LIMIT = 8'(AGE_MAX);

  logic [NUM_PORTS-1:0] req_vec, gnt_vec, aged_vec, rvalid_vec, err_vec;
  logic                 we_arr    [NUM_PORTS];
  logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_arr [NUM_PORTS];
  logic [SW-1:0]        wstrb_arr [NUM_PORTS];
  logic [DATA_W-1:0]    rdata_arr [NUM_PORTS];

  assign req_vec[PORT_IF]    = if_req;
  assign req_vec[PORT_MEM]   = mem_req;
  assign req_vec[PORT_VEC]   = vec_req;
  assign we_arr[PORT_IF]     = if_we;
  assign we_arr[PORT_MEM]    = mem_we;
  assign we_arr[PORT_VEC]    = vec_we;
  assign addr_arr[PORT_IF]   = if_addr;
  assign addr_arr[PORT_MEM]  = mem_addr;
  assign addr_arr[PORT_VEC]  = vec_addr;
  assign wdata_arr[PORT_IF]  = if_wdata;
  assign wdata_arr[PORT_MEM] = mem_wdata;
  assign wdata_arr[PORT_VEC] = vec_wdata;
  assign wstrb_arr[PORT_IF]  = if_wstrb;
  assign wstrb_arr[PORT_MEM] = mem_wstrb;
  assign wstrb_arr[PORT_VEC] = vec_wstrb;

  state_t              state_reg;
  logic [1:0]          owner_reg;
  logic                m_req_reg, m_we_reg;
  logic [ADDR_W-1:0]   m_addr_reg;
  logic [DATA_W-1:0]   m_wdata_reg;
  logic [SW-1:0]       m_wstrb_reg;
  winner_t             win;
  logic                arb_en, ack_fire;

  assign win      = pick_winner(req_vec, aged_vec);
  assign arb_en   = (state_reg != ISSUE);
  assign ack_fire = (state_reg == ISSUE) && m_ack;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic              rvalid_reg, err_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              owner_done;

    assign gnt_vec[gi] = arb_en && win.valid && (win.idx == 2'(gi));
    assign owner_done  = ack_fire && (owner_reg == 2'(gi));

    age_counter u_age (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (req_vec[gi] & ~gnt_vec[gi]),
      .clr   (gnt_vec[gi] | ~req_vec[gi]),
      .limit (AGE_LIMIT),
      .aged  (aged_vec[gi])
    );

    // Response data is held per port so each requester sees only its own results.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        rvalid_reg <= 1'b0;
        err_reg    <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= owner_done;
        if (owner_done) begin
          rdata_reg <= m_rdata;
          err_reg   <= m_err;
        end
      end
    end

    assign rvalid_vec[gi] = rvalid_reg;
    assign err_vec[gi]    = err_reg;
    assign rdata_arr[gi]  = rdata_reg;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      owner_reg   <= 2'd0;
      m_req_reg   <= 1'b0;
      m_we_reg    <= 1'b0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      m_wstrb_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, RESP: begin
          if (win.valid) begin
            state_reg   <= ISSUE;
            owner_reg   <= win.idx;
            m_req_reg   <= 1'b1;
            m_we_reg    <= we_arr[win.idx];
            m_addr_reg  <= addr_arr[win.idx];
            m_wdata_reg <= wdata_arr[win.idx];
            m_wstrb_reg <= wstrb_arr[win.idx];
          end else begin
            state_reg <= IDLE;
          end
        end
        ISSUE: begin
          if (m_ack) begin
            m_req_reg <= 1'b0;
            state_reg <= RESP;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_req   = m_req_reg;
  assign m_we    = m_we_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;
  assign m_wstrb = m_wstrb_reg;

  assign if_gnt     = gnt_vec[PORT_IF];
  assign mem_gnt    = gnt_vec[PORT_MEM];
  assign vec_gnt    = gnt_vec[PORT_VEC];
  assign if_rvalid  = rvalid_vec[PORT_IF];
  assign mem_rvalid = rvalid_vec[PORT_MEM];
  assign vec_rvalid = rvalid_vec[PORT_VEC];
  assign if_err     = err_vec[PORT_IF];
  assign mem_err    = err_vec[PORT_MEM];
  assign vec_err    = err_vec[PORT_VEC];
  assign if_rdata   = rdata_arr[PORT_IF];
  assign mem_rdata  = rdata_arr[PORT_MEM];
  assign vec_rdata  = rdata_arr[PORT_VEC];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-timeline reference model.
module tb_mem_port_arbiter;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int AGE = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [2:0]    req, we;
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];
  logic [SW-1:0] wstrb [3];
  logic [2:0]    gnt, rvalid, err;
  logic [DW-1:0] rdata [3];
  logic          m_req, m_we, m_ack, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AGE_MAX(AGE)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(req[0]), .if_we(we[0]), .if_addr(addr[0]), .if_wdata(wdata[0]), .if_wstrb(wstrb[0]),
    .if_gnt(gnt[0]), .if_rvalid(rvalid[0]), .if_rdata(rdata[0]), .if_err(err[0]),
    .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
    .mem_gnt(gnt[1]), .mem_rvalid(rvalid[1]), .mem_rdata(rdata[1]), .mem_err(err[1]),
    .vec_req(req[2]), .vec_we(we[2]), .vec_addr(addr[2]), .vec_wdata(wdata[2]), .vec_wstrb(wstrb[2]),
    .vec_gnt(gnt[2]), .vec_rvalid(rvalid[2]), .vec_rdata(rdata[2]), .vec_err(err[2]),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req = '0; we = '0; m_ack = 1'b0; m_rdata = '0; m_err = 1'b0;
    for (int p = 0; p < 3; p++) begin
      addr[p] = '0; wdata[p] = '0; wstrb[p] = '0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  typedef struct packed {
    logic [2:0]  req;
    logic        ack;
    logic [63:0] rd;
    logic [2:0]  gnt;
    logic        mreq;
    logic [2:0]  rv;
    logic [63:0] rd_exp;
    logic [63:0] maddr;
  } vec_t;

  vec_t tbl [8];

  // Reference model state (random phase)
  int            ages [3];
  bit            open_txn;
  int            gcyc, acyc, owner, rport;
  logic [DW-1:0] last_rd [3];
  logic          last_err [3];
  bit            pend [3];
  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata;
  logic [SW-1:0] t_wstrb;

  initial begin
    int vec_c, mem_c;
    int order [3];
    clear_inputs();
    do_reset();

    // ---- reset state
    settle();
    chk("reset_gnt", gnt, 3'b000);
    chk("reset_rvalid", rvalid, 3'b000);
    chk("reset_err", err, 3'b000);
    chk("reset_m_req", m_req, 1'b0);
    chk("reset_m_addr", m_addr, 64'h0);
    chk("reset_if_rdata", rdata[0], 64'h0);
    tick();

    // ---- single read from if, 3 wait cycles
    req[0] = 1'b1; addr[0] = 64'h1000;
    settle();
    chk("single_gnt", gnt, 3'b001);
    chk("single_mreq_c0", m_req, 1'b0);
    tick();
    req[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin m_ack = 1'b1; m_rdata = 64'hDEADBEEF; end
      settle();
      chk("single_mreq", m_req, 1'b1);
      chk("single_no_rvalid", rvalid, 3'b000);
      if (k == 1) begin
        chk("single_m_addr", m_addr, 64'h1000);
        chk("single_m_we", m_we, 1'b0);
      end
      tick();
    end
    m_ack = 1'b0;
    settle();
    chk("single_rvalid", rvalid, 3'b001);
    chk("single_rdata", rdata[0], 64'hDEADBEEF);
    chk("single_err", err[0], 1'b0);
    chk("single_mreq_done", m_req, 1'b0);
    $display("txn single_read port=if rdata=0x%0h", rdata[0]);
    tick();
    settle();
    chk("single_rvalid_pulse", rvalid, 3'b000);
    tick();

    // ---- table: three simultaneous requests, zero-wait memory
    tbl[0] = '{3'b111, 1'b1, 64'hBAD,  3'b010, 1'b0, 3'b000, 64'h0,    64'h0};
    tbl[1] = '{3'b101, 1'b1, 64'h1111, 3'b000, 1'b1, 3'b000, 64'h0,    64'h200};
    tbl[2] = '{3'b101, 1'b0, 64'h0,    3'b001, 1'b0, 3'b010, 64'h1111, 64'h0};
    tbl[3] = '{3'b100, 1'b1, 64'h2222, 3'b000, 1'b1, 3'b000, 64'h0,    64'h100};
    tbl[4] = '{3'b100, 1'b0, 64'h0,    3'b100, 1'b0, 3'b001, 64'h2222, 64'h0};
    tbl[5] = '{3'b000, 1'b1, 64'h3333, 3'b000, 1'b1, 3'b000, 64'h0,    64'h300};
    tbl[6] = '{3'b000, 1'b0, 64'h0,    3'b000, 1'b0, 3'b100, 64'h3333, 64'h0};
    tbl[7] = '{3'b000, 1'b0, 64'h0,    3'b000, 1'b0, 3'b000, 64'h0,    64'h0};
    for (int p = 0; p < 3; p++) addr[p] = 64'h100 * (p + 1);
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; m_ack = tbl[i].ack; m_rdata = tbl[i].rd;
      settle();
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_mreq", i), m_req, tbl[i].mreq);
      chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].rv);
      if (tbl[i].mreq) chk($sformatf("tbl%0d_maddr", i), m_addr, tbl[i].maddr);
      for (int p = 0; p < 3; p++)
        if (tbl[i].rv[p]) begin
          chk($sformatf("tbl%0d_rdata", i), rdata[p], tbl[i].rd_exp);
          $display("txn table port=%0d rdata=0x%0h", p, rdata[p]);
        end
      tick();
    end
    clear_inputs();

    // ---- aging: mem and vec request continuously, zero-wait memory
    req = 3'b110; m_ack = 1'b1;
    vec_c = -1; mem_c = -1;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (gnt[2] && vec_c < 0) vec_c = c;
      if (vec_c >= 0 && c > vec_c && gnt[1] && mem_c < 0) mem_c = c;
      tick();
    end
    chk("age_vec_gnt_cycle", 64'(vec_c), 64'(4));
    chk("age_mem_resume_cycle", 64'(mem_c), 64'(6));
    $display("txn aging vec_gnt_cycle=%0d mem_resume_cycle=%0d", vec_c, mem_c);
    req = '0;
    repeat (3) tick();
    clear_inputs();
    tick();

    // ---- mem write with error, then a clean transaction
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 64'h2000; wdata[1] = 64'h55; wstrb[1] = 8'h0F;
    settle();
    chk("werr_gnt", gnt, 3'b010);
    tick();
    req[1] = 1'b0; m_ack = 1'b1; m_err = 1'b1; m_rdata = 64'h77;
    settle();
    chk("werr_m_we", m_we, 1'b1);
    chk("werr_m_wdata", m_wdata, 64'h55);
    chk("werr_m_wstrb", m_wstrb, 8'h0F);
    tick();
    m_ack = 1'b0; m_err = 1'b0;
    settle();
    chk("werr_rvalid", rvalid, 3'b010);
    chk("werr_err", err[1], 1'b1);
    chk("werr_rdata", rdata[1], 64'h77);
    $display("txn write_err port=mem err=%0d", err[1]);
    tick();
    settle();
    chk("werr_rvalid_pulse", rvalid, 3'b000);
    tick();
    req[1] = 1'b1; we[1] = 1'b0;
    settle();
    chk("clean_gnt", gnt, 3'b010);
    tick();
    req[1] = 1'b0; m_ack = 1'b1; m_rdata = 64'h99;
    tick();
    m_ack = 1'b0;
    settle();
    chk("clean_rvalid", rvalid, 3'b010);
    chk("clean_err", err[1], 1'b0);
    $display("txn clean port=mem err=%0d", err[1]);
    tick();

    // ---- reset in the middle of ISSUE, late ack ignored
    req[0] = 1'b1; addr[0] = 64'h3000;
    settle();
    chk("rst_gnt", gnt, 3'b001);
    tick();
    req[0] = 1'b0;
    settle();
    chk("rst_mreq_before", m_req, 1'b1);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1; m_ack = 1'b1; m_rdata = 64'hFFFF;
    settle();
    chk("rst_mreq_after", m_req, 1'b0);
    chk("rst_m_addr", m_addr, 64'h0);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_rdata_mem", rdata[1], 64'h0);
    chk("rst_err", err, 3'b000);
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 1) m_ack = 1'b0;
      settle();
      chk("rst_no_rvalid", rvalid, 3'b000);
      chk("rst_no_mreq", m_req, 1'b0);
      tick();
    end
    req[0] = 1'b1; addr[0] = 64'h4000;
    settle();
    chk("post_rst_gnt", gnt, 3'b001);
    tick();
    req[0] = 1'b0; m_ack = 1'b1; m_rdata = 64'hABCD;
    settle();
    chk("post_rst_maddr", m_addr, 64'h4000);
    tick();
    m_ack = 1'b0;
    settle();
    chk("post_rst_rvalid", rvalid, 3'b001);
    chk("post_rst_rdata", rdata[0], 64'hABCD);
    $display("txn post_reset port=if rdata=0x%0h", rdata[0]);
    tick();

    // ---- vec drops its request while blocked by mem
    req[1] = 1'b1;
    settle();
    chk("drop_mem_gnt", gnt, 3'b010);
    tick();
    req[1] = 1'b0; req[2] = 1'b1;
    settle();
    chk("drop_no_gnt_c1", gnt, 3'b000);
    tick();
    tick();
    req[2] = 1'b0;
    settle();
    chk("drop_vec_age_before", dut.g_port[2].u_age.cnt_reg, 8'd2);
    tick();
    m_ack = 1'b1;
    settle();
    chk("drop_vec_age_cleared", dut.g_port[2].u_age.cnt_reg, 8'd0);
    tick();
    m_ack = 1'b0;
    settle();
    chk("drop_mem_rvalid", rvalid, 3'b010);
    tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("drop_no_vec_gnt", gnt, 3'b000);
      chk("drop_no_vec_rvalid", rvalid, 3'b000);
      tick();
    end
    $display("txn drop port=vec abandoned");

    // ---- randomized traffic against the timeline model
    clear_inputs();
    do_reset();
    order = '{1, 0, 2};
    open_txn = 1'b0; gcyc = 0; acyc = -10; owner = 0; rport = 0;
    t_we = 1'b0; t_addr = '0; t_wdata = '0; t_wstrb = '0;
    for (int p = 0; p < 3; p++) begin
      ages[p] = 0; last_rd[p] = '0; last_err[p] = 1'b0; pend[p] = 1'b0;
    end
    for (int c = 0; c < 2000; c++) begin
      logic [2:0] exp_gnt, exp_rv;
      logic       exp_mreq;
      int         w;
      for (int p = 0; p < 3; p++) begin
        if (pend[p]) begin
          if ($urandom_range(15) == 0) pend[p] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          pend[p]  = 1'b1;
          we[p]    = 1'($urandom_range(1));
          addr[p]  = {$urandom, $urandom};
          wdata[p] = {$urandom, $urandom};
          wstrb[p] = 8'($urandom);
        end
        req[p] = pend[p];
      end
      m_ack   = 1'($urandom_range(1));
      m_rdata = {$urandom, $urandom};
      m_err   = ($urandom_range(7) == 0);

      w = -1;
      if (!open_txn) begin
        for (int k = 0; k < 3; k++)
          if (w < 0 && req[order[k]] && ages[order[k]] >= AGE) w = order[k];
        for (int k = 0; k < 3; k++)
          if (w < 0 && req[order[k]]) w = order[k];
      end
      exp_gnt  = (w >= 0) ? 3'(1 << w) : 3'b000;
      exp_mreq = open_txn && (c > gcyc);
      exp_rv   = (c == acyc + 1) ? 3'(1 << rport) : 3'b000;

      settle();
      chk("rnd_gnt", gnt, exp_gnt);
      chk("rnd_mreq", m_req, exp_mreq);
      chk("rnd_rvalid", rvalid, exp_rv);
      for (int p = 0; p < 3; p++) begin
        chk("rnd_rdata", rdata[p], last_rd[p]);
        chk("rnd_err", err[p], last_err[p]);
      end
      if (exp_mreq) begin
        chk("rnd_m_we", m_we, t_we);
        chk("rnd_m_addr", m_addr, t_addr);
        chk("rnd_m_wdata", m_wdata, t_wdata);
        chk("rnd_m_wstrb", m_wstrb, t_wstrb);
      end
      if (exp_rv != 3'b000)
        $display("txn rnd cycle=%0d port=%0d rdata=0x%0h err=%0d", c, rport, last_rd[rport], last_err[rport]);

      for (int p = 0; p < 3; p++)
        ages[p] = (req[p] && !exp_gnt[p]) ? ((ages[p] + 1 > AGE) ? AGE : ages[p] + 1) : 0;
      if (exp_mreq && m_ack) begin
        open_txn = 1'b0;
        acyc = c;
        rport = owner;
        last_rd[owner] = m_rdata;
        last_err[owner] = m_err;
      end
      if (w >= 0) begin
        open_txn = 1'b1;
        gcyc = c;
        owner = w;
        t_we = we[w]; t_addr = addr[w]; t_wdata = wdata[w]; t_wstrb = wstrb[w];
        pend[w] = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
